uart_fifo_bridge: RTL and testbench

Parametrised UART endpoint with independent RX and TX FIFOs, a shared baud/oversample tick generator, and a run-time mode select. In loopback mode, received characters drain from the RX FIFO into the TX FIFO and are retransmitted without host involvement. In host mode, a local master pops the RX FIFO and pushes the TX FIFO. Adds configurable data width, FIFO depth and baud rate, fill levels, sticky overflow and framing-error flags.

---
 rtl/uart_fifo_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: UART endpoint with RX/TX FWFT FIFOs, shared 16x tick generator,
// run-time loopback/host mode and sticky overflow/framing flags.
module uart_fifo_bridge_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          ovf
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic full, do_push, do_pop;
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    // a pop in the same cycle frees the slot, so a push while full still lands
    assign do_push = push && (!full || do_pop);
    assign ovf = push && !do_push;
    assign rdata = empty ? '0 : mem[rptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wptr] <= wdata;
endmodule

module uart_fifo_bridge #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 mode_loop,
    input  logic                 clear_err,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rx_empty,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 tx_full,
    output logic [CW-1:0]        rx_count,
    output logic [CW-1:0]        tx_count,
    output logic                 tx_busy,
    output logic                 rx_ovf,
    output logic                 tx_ovf,
    output logic                 frame_err
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t rx_state, rx_state_n, tx_state, tx_state_n;
    logic [31:0] div_cnt;
    logic [3:0] rx_tcnt, rx_tcnt_n, tx_tcnt, tx_tcnt_n;
    logic [2:0] rx_bit, rx_bit_n, tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_n, tx_sh, tx_sh_n, tx_head, tx_wdata;
    logic tick, rx_s1, rx_s2, mode_q, rx_push, rx_push_n, fe_evt, tx_n, tx_pop, tx_empty;
    logic xfer, rx_pop, tx_push, rx_ovf_evt, tx_ovf_evt;

    assign tick = div_cnt == 32'(DIV - 1);
    assign xfer = mode_q && !rx_empty && !tx_full;
    assign rx_pop = mode_q ? xfer : rd_en;
    assign tx_push = mode_q ? xfer : wr_en;
    assign tx_wdata = mode_q ? rd_data : wr_data;
    assign tx_full = tx_count == CW'(FIFO_DEPTH);
    assign tx_busy = tx_state != IDLE || tx_pop;

    uart_fifo_bridge_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rx_sh),
        .rdata(rd_data), .count(rx_count), .empty(rx_empty), .ovf(rx_ovf_evt)
    );
    uart_fifo_bridge_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(tx_wdata),
        .rdata(tx_head), .count(tx_count), .empty(tx_empty), .ovf(tx_ovf_evt)
    );

    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n = tick ? rx_tcnt + 1'b1 : rx_tcnt;
        rx_bit_n = rx_bit;
        rx_sh_n = rx_sh;
        rx_push_n = 1'b0;
        fe_evt = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_tcnt_n = '0;
                rx_state_n = rx_s2 ? IDLE : START;
            end
            START: if (tick && rx_tcnt == 4'd7) begin
                rx_tcnt_n = '0;
                rx_bit_n = '0;
                rx_state_n = rx_s2 ? IDLE : DATA;
            end
            DATA: if (tick && rx_tcnt == 4'd15) begin
                rx_sh_n = {rx_s2, rx_sh[DATA_BITS-1:1]};
                rx_bit_n = rx_bit + 1'b1;
                rx_state_n = rx_bit == LAST ? STOP : DATA;
            end
            STOP: if (tick && rx_tcnt == 4'd15) begin
                rx_push_n = rx_s2;
                fe_evt = !rx_s2;
                rx_state_n = IDLE;
            end
        endcase
    end

    // each bit level is driven on the tick where tcnt is 0 and held for 16 ticks
    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n = tick ? tx_tcnt + 1'b1 : tx_tcnt;
        tx_bit_n = tx_bit;
        tx_sh_n = tx_sh;
        tx_n = tx;
        tx_pop = 1'b0;
        if (tx_state != IDLE && tick && tx_tcnt == '0)
            tx_n = tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
        case (tx_state)
            IDLE: begin
                tx_tcnt_n = '0;
                tx_pop = !tx_empty;
            end
            START: if (tick && tx_tcnt == 4'd15) begin
                tx_bit_n = '0;
                tx_state_n = DATA;
            end
            DATA: if (tick && tx_tcnt == 4'd15) begin
                tx_sh_n = tx_sh >> 1;
                tx_bit_n = tx_bit + 1'b1;
                tx_state_n = tx_bit == LAST ? STOP : DATA;
            end
            STOP: if (tick && tx_tcnt == 4'd15) begin
                tx_pop = !tx_empty;
                tx_state_n = IDLE;
            end
        endcase
        if (tx_pop) begin
            tx_sh_n = tx_head;
            tx_state_n = START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            mode_q <= 1'b0;
            rx_state <= IDLE;
            rx_tcnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
            rx_push <= 1'b0;
            tx_state <= IDLE;
            tx_tcnt <= '0;
            tx_bit <= '0;
            tx_sh <= '0;
            tx <= 1'b1;
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            mode_q <= mode_loop;
            rx_state <= rx_state_n;
            rx_tcnt <= rx_tcnt_n;
            rx_bit <= rx_bit_n;
            rx_sh <= rx_sh_n;
            rx_push <= rx_push_n;
            tx_state <= tx_state_n;
            tx_tcnt <= tx_tcnt_n;
            tx_bit <= tx_bit_n;
            tx_sh <= tx_sh_n;
            tx <= tx_n;
            rx_ovf <= rx_ovf_evt || (rx_ovf && !clear_err);
            tx_ovf <= tx_ovf_evt || (tx_ovf && !clear_err);
            frame_err <= fe_evt || (frame_err && !clear_err);
        end
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed checks of uart_fifo_bridge at 16 clk/bit,
// one 8-bit instance for RX/loopback/FIFO work and one 7-bit instance for TX framing.
module tb_uart_fifo_bridge;
    localparam int CF = 1600000;
    localparam int BD = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic rx8 = 1'b1, mode8 = 1'b0, clr8 = 1'b0, rd_en8 = 1'b0, wr_en8 = 1'b0;
    logic [7:0] wr_data8 = '0, rd_data8;
    logic tx8, rx_empty8, tx_full8, tx_busy8, rx_ovf8, tx_ovf8, fe8;
    logic [4:0] rx_count8, tx_count8;

    logic rx7 = 1'b1, mode7 = 1'b0, clr7 = 1'b0, rd_en7 = 1'b0, wr_en7 = 1'b0;
    logic [6:0] wr_data7 = '0, rd_data7;
    logic tx7, rx_empty7, tx_full7, tx_busy7, rx_ovf7, tx_ovf7, fe7;
    logic [4:0] rx_count7, tx_count7;

    uart_fifo_bridge #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(8), .FIFO_DEPTH(16)) dut8 (
        .clk(clk), .rst(rst), .rx(rx8), .tx(tx8), .mode_loop(mode8), .clear_err(clr8),
        .rd_en(rd_en8), .rd_data(rd_data8), .rx_empty(rx_empty8), .wr_en(wr_en8),
        .wr_data(wr_data8), .tx_full(tx_full8), .rx_count(rx_count8), .tx_count(tx_count8),
        .tx_busy(tx_busy8), .rx_ovf(rx_ovf8), .tx_ovf(tx_ovf8), .frame_err(fe8)
    );
    uart_fifo_bridge #(.CLK_FREQ(CF), .BAUD(BD), .DATA_BITS(7), .FIFO_DEPTH(16)) dut7 (
        .clk(clk), .rst(rst), .rx(rx7), .tx(tx7), .mode_loop(mode7), .clear_err(clr7),
        .rd_en(rd_en7), .rd_data(rd_data7), .rx_empty(rx_empty7), .wr_en(wr_en7),
        .wr_data(wr_data7), .tx_full(tx_full7), .rx_count(rx_count7), .tx_count(tx_count7),
        .tx_busy(tx_busy7), .rx_ovf(rx_ovf7), .tx_ovf(tx_ovf7), .frame_err(fe7)
    );

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         cnt;
        logic       fe;
        logic [7:0] head;
    } vec_t;
    vec_t tbl[6];

    int ncmp = 0, nbad = 0, k;
    logic [7:0] got;
    logic [12:0] cap;
    logic bok;
    logic [7:0] exp_pop[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // called on a negedge; ends on a negedge after a 30-clk idle gap
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx8 = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx8 = d[i];
            repeat (16) @(negedge clk);
        end
        rx8 = stop;
        repeat (16) @(negedge clk);
        rx8 = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{8'h3C, 1'b0, 0, 1'b1, 8'h00};
        tbl[1] = '{8'h55, 1'b1, 1, 1'b1, 8'h55};
        tbl[2] = '{8'hA5, 1'b1, 2, 1'b1, 8'h55};
        tbl[3] = '{8'h00, 1'b1, 3, 1'b1, 8'h55};
        tbl[4] = '{8'hFF, 1'b0, 3, 1'b1, 8'h55};
        tbl[5] = '{8'h81, 1'b1, 4, 1'b1, 8'h55};
        exp_pop = '{8'h55, 8'hA5, 8'h00, 8'h81};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("rst tx", tx8, 1);
        chk("rst tx_busy", tx_busy8, 0);
        chk("rst rx_empty", rx_empty8, 1);
        chk("rst tx_full", tx_full8, 0);
        chk("rst rx_count", rx_count8, 0);
        chk("rst tx_count", tx_count8, 0);
        chk("rst flags", {rx_ovf8, tx_ovf8, fe8}, 0);
        chk("rst rd_data", rd_data8, 0);
        chk("rst tx7", tx7, 1);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].d, tbl[i].stop);
            chk($sformatf("tbl%0d rx_count", i), rx_count8, tbl[i].cnt);
            chk($sformatf("tbl%0d frame_err", i), fe8, tbl[i].fe);
            chk($sformatf("tbl%0d rd_data", i), rd_data8, tbl[i].head);
        end

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop%0d", i), rd_data8, exp_pop[i]);
            rd_en8 = 1'b1;
            @(negedge clk);
            rd_en8 = 1'b0;
        end
        chk("drained rx_empty", rx_empty8, 1);
        rd_en8 = 1'b1;
        @(negedge clk);
        rd_en8 = 1'b0;
        chk("pop empty count", rx_count8, 0);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk("clear frame_err", fe8, 0);

        rx8 = 1'b0;
        repeat (4) @(negedge clk);
        rx8 = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch rx_count", rx_count8, 0);
        chk("glitch frame_err", fe8, 0);

        mode8 = 1'b1;
        repeat (4) @(negedge clk);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                k = 0;
                while (tx8 === 1'b1 && k < 400) begin
                    @(negedge clk);
                    k++;
                end
                // stop sample lands 2 sync + 1 + 8 + 9*16 = 155 clk after the start edge
                chk("loop fall within 4 clk of stop sample", k > 155 && k <= 159, 1);
                repeat (8) @(negedge clk);
                chk("loop start bit", tx8, 0);
                for (int j = 0; j < 8; j++) begin
                    repeat (16) @(negedge clk);
                    got[j] = tx8;
                end
                chk("loop data", got, 8'hA5);
                repeat (16) @(negedge clk);
                chk("loop stop bit", tx8, 1);
            end
        join
        for (int w = 0; w < 200 && (rx_count8 != 0 || tx_count8 != 0 || tx_busy8); w++)
            @(negedge clk);
        chk("loop counts", {rx_count8, tx_count8}, 0);
        chk("loop tx_busy", tx_busy8, 0);
        mode8 = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        chk("ovf rx_count", rx_count8, 16);
        chk("ovf rx_ovf", rx_ovf8, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf pop%0d", i), rd_data8, 8'(i));
            rd_en8 = 1'b1;
            @(negedge clk);
            rd_en8 = 1'b0;
        end
        chk("ovf drained", rx_empty8, 1);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk("ovf cleared", rx_ovf8, 0);

        for (int i = 0; i < 18; i++) begin
            wr_en8 = 1'b1;
            wr_data8 = 8'(i + 8'h40);
            @(negedge clk);
        end
        chk("txovf tx_count", tx_count8, 16);
        chk("txovf tx_full", tx_full8, 1);
        chk("txovf tx_ovf", tx_ovf8, 1);
        clr8 = 1'b1;
        @(negedge clk);
        wr_en8 = 1'b0;
        clr8 = 1'b0;
        chk("txovf set wins over clear", tx_ovf8, 1);
        chk("txovf count held", tx_count8, 16);
        clr8 = 1'b1;
        @(negedge clk);
        clr8 = 1'b0;
        chk("txovf cleared", tx_ovf8, 0);
        for (int w = 0; w < 4000 && (tx_count8 != 0 || tx_busy8); w++) @(negedge clk);
        chk("txovf drained", {tx_count8, tx_busy8}, 0);

        wr_en7 = 1'b1;
        wr_data7 = 7'h7F;
        @(negedge clk);
        wr_data7 = 7'h01;
        @(negedge clk);
        wr_en7 = 1'b0;
        k = 0;
        bok = 1'b1;
        while (tx7 === 1'b1 && k < 20) begin
            bok = bok & tx_busy7;
            @(negedge clk);
            k++;
        end
        chk("d7 fall on next tick", k, 1);
        cap = '0;
        for (int t = 0; t <= 200; t++) begin
            bok = bok & tx_busy7;
            if (t % 16 == 8) cap[(t - 8) / 16] = tx7;
            @(negedge clk);
        end
        // frame 0x7F (start, 7 ones, stop) then start, 1, 0, 0 of 0x01 with no gap
        chk("d7 bit stream", cap, 13'h05FE);
        chk("d7 tx_busy held", bok, 1);
        chk("d7 tx_count", tx_count7, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("d7 rst tx", tx7, 1);
        chk("d7 rst tx_busy", tx_busy7, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
